spio_hss_multiplexer_tx_scheduler: RTL and testbench
====================================================

# spio_hss_multiplexer_tx_scheduler

Round-robin scheduler that shares the single outbound frame-assembly path of the HSS multiplexer between the eight TX packet streams. It sits between the eight `TX_PKTn` valid/ready interfaces and the frame assembler's packet input. Grants are gated by link handshake status and by per-channel remote stop (flow-control) bits. The winning packet is presented through a one-entry registered output stage together with its channel number.

## Interface
- `PKT_BITS`, default 72: width of one packet.
- `NUM_CHANS`, fixed 8: number of streams; the only supported value.

- `CLK_IN`  in  1  sole clock.
- `RESET_IN`  in  1  asynchronous, active-low reset.
- `ENABLE_IN`  in  1  handshake complete; new grants are allowed only while high.
- `STOP_IN`  in  8  remote stop mask; bit i high blocks new grants to channel i.
- `PKT_DATA_IN`  in  8×PKT_BITS  channel i occupies bits [i×PKT_BITS +: PKT_BITS].
- `PKT_VLD_IN`  in  8  per-channel valid.
- `PKT_RDY_OUT`  out  8  per-channel ready; one-hot or zero.
- `OUT_DATA_OUT`  out  PKT_BITS  granted packet.
- `OUT_CHAN_OUT`  out  3  channel of `OUT_DATA_OUT`.
- `OUT_VLD_OUT`  out  1  output stage holds a packet.
- `OUT_RDY_IN`  in  1  frame assembler accepts the packet.
- `REG_ADDR_IN`  in  4  counter select (see Configuration).
- `REG_DATA_OUT`  out  32  counter read data.

## Operation
- **Eligibility.** Channel i is eligible when `PKT_VLD_IN[i] & ~STOP_IN[i] & ENABLE_IN`.
- **Load condition.** The output stage is free when `~OUT_VLD_OUT | OUT_RDY_IN`. This gives back-to-back operation with a drain and a load in the same cycle.
- **Grant.** When the stage is free and any channel is eligible, the eligible channel is granted in round-robin order. The search starts at `last_grant+1` modulo 8.
  - `PKT_RDY_OUT[g]` is asserted for the granted channel in the same cycle; this is a combinational function of the inputs and current state.
  - On the next edge, the data and channel are registered, `OUT_VLD_OUT` is set, and `last_grant` becomes g.
- **Gating.** `PKT_RDY_OUT` is all-zero when the stage is not free or when no channel is eligible.
- **Idle.** If the stage drains and nothing is eligible, `OUT_VLD_OUT` clears on the next edge. `last_grant` is unchanged.
- **STOP_IN and ENABLE_IN** affect only new grants. A packet already held in the output stage is never discarded and is presented until `OUT_RDY_IN`.
- **No reordering.** Packets within a channel are never reordered. No packet is duplicated or lost except on reset.
- **Fairness.** With all 8 channels continuously eligible and `OUT_RDY_IN` = 1, grants follow 0,1,…,7,0,… with 1 packet per cycle.
- **Reset.**
  - Outputs: `OUT_VLD_OUT`=0, `OUT_DATA_OUT`=0, `OUT_CHAN_OUT`=0, `PKT_RDY_OUT`=0 (held while `RESET_IN` is low), `REG_DATA_OUT`=0.
  - State: `last_grant`=7, so channel 0 is first. All counters are 0.
  - Reset mid-transfer drops the held packet.

## Timing
- Latency is 1 cycle: a packet accepted on edge N (`PKT_VLD_IN[i]` & `PKT_RDY_OUT[i]`) is visible on `OUT_*` after edge N.
- Sustained throughput is 1 packet/cycle while `OUT_RDY_IN`=1.
- `OUT_DATA_OUT`, `OUT_CHAN_OUT` and `OUT_VLD_OUT` are registered and stable while `OUT_VLD_OUT & ~OUT_RDY_IN`.
- `STOP_IN[i]` rising in cycle N prevents a grant to channel i in cycle N.
- `ENABLE_IN` falling in cycle N prevents any grant in cycle N.

## Configuration
- Macro: `SPIO_HSS_MULTIPLEXER_TX_SCHED_COUNTERS_EN`.
- **Defined:**
  - Eight 32-bit counters, one per channel, count grants and wrap from 0xFFFF_FFFF to 0.
  - Counter 8 counts cycles with `OUT_VLD_OUT & ~OUT_RDY_IN` (back-pressure), also wrapping.
  - `REG_DATA_OUT` combinationally returns counter `REG_ADDR_IN` for addresses 0–8, and 0 for addresses 9–15.
- **Undefined:** no counters are implemented. `REG_DATA_OUT` is constant 0 and `REG_ADDR_IN` is ignored.

## Test plan
- **Fairness:** all 8 channels valid, `STOP_IN`=0, `ENABLE_IN`=1, `OUT_RDY_IN`=1 for 16 cycles -> `OUT_CHAN_OUT` sequence is 0..7,0..7 with `OUT_VLD_OUT` continuously high.
- **Stop mask:** as the fairness test, but `STOP_IN`=8'b0000_0100 -> channel 2 is never granted and the sequence is 0,1,3,4,5,6,7,0. Clearing stop at a cycle when `last_grant`=1 -> next grant is 2.
- **Back-pressure:** channel 5 is granted packet 0xA5, then `OUT_RDY_IN`=0 for 4 cycles -> output holds 0xA5/chan 5 and `PKT_RDY_OUT`=0. Raising `OUT_RDY_IN` -> same-cycle grant of the next eligible channel. Back-pressure counter reads 4.
- **Enable drop:** `ENABLE_IN`→0 with a packet held -> the held packet is delivered once, then `OUT_VLD_OUT`=0 and no `PKT_RDY_OUT` until `ENABLE_IN`=1.
- **Async reset:** assert `RESET_IN` low mid-transfer, between clock edges -> `OUT_VLD_OUT` and `PKT_RDY_OUT` go to 0 immediately. After release, the first grant goes to the lowest eligible channel starting from 0.
- **Counters (macro defined):** 3 grants to channel 0 and 2 grants to channel 7 -> `REG_ADDR_IN`=0 reads 3, 7 reads 2, 12 reads 0. Preload channel 0 via 2^32 grants in simulation (force) -> wraps to 0.

Source files
------------

// File: rtl/spio_hss_multiplexer_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// spio_hss_multiplexer_tx_scheduler_if
//
// Bundles the TX scheduler's packet, flow-control, output and counter-read
// signals so that they can be passed as one port.
//   slave  : the scheduler's view (consumes TX_PKTn, produces the output stage)
//   master : the surrounding logic's view (drives TX_PKTn, sinks the output)
// Signals:
//   ENABLE_IN     link handshake complete; new grants are allowed only while high
//   STOP_IN[7:0]  remote stop mask, one bit per channel
//   PKT_DATA_IN   8 packets, channel i at [i*PKT_BITS +: PKT_BITS]
//   PKT_VLD_IN    per-channel valid
//   PKT_RDY_OUT   per-channel ready (one-hot or zero)
//   OUT_DATA_OUT  granted packet
//   OUT_CHAN_OUT  channel number of OUT_DATA_OUT
//   OUT_VLD_OUT   output stage holds a packet
//   OUT_RDY_IN    frame assembler accepts the held packet
//   REG_ADDR_IN   counter select
//   REG_DATA_OUT  counter read data
// -----------------------------------------------------------------------------
interface spio_hss_multiplexer_tx_scheduler_if #(
    parameter int PKT_BITS = 72
);
    logic                  ENABLE_IN;
    logic [7:0]            STOP_IN;
    logic [8*PKT_BITS-1:0] PKT_DATA_IN;
    logic [7:0]            PKT_VLD_IN;
    logic [7:0]            PKT_RDY_OUT;
    logic [PKT_BITS-1:0]   OUT_DATA_OUT;
    logic [2:0]            OUT_CHAN_OUT;
    logic                  OUT_VLD_OUT;
    logic                  OUT_RDY_IN;
    logic [3:0]            REG_ADDR_IN;
    logic [31:0]           REG_DATA_OUT;

    modport slave (
        input  ENABLE_IN,
        input  STOP_IN,
        input  PKT_DATA_IN,
        input  PKT_VLD_IN,
        output PKT_RDY_OUT,
        output OUT_DATA_OUT,
        output OUT_CHAN_OUT,
        output OUT_VLD_OUT,
        input  OUT_RDY_IN,
        input  REG_ADDR_IN,
        output REG_DATA_OUT
    );

    modport master (
        output ENABLE_IN,
        output STOP_IN,
        output PKT_DATA_IN,
        output PKT_VLD_IN,
        input  PKT_RDY_OUT,
        input  OUT_DATA_OUT,
        input  OUT_CHAN_OUT,
        input  OUT_VLD_OUT,
        output OUT_RDY_IN,
        output REG_ADDR_IN,
        input  REG_DATA_OUT
    );
endinterface

// File: rtl/spio_hss_multiplexer_tx_scheduler.sv
// -----------------------------------------------------------------------------
// spio_hss_multiplexer_tx_scheduler
//
// Round-robin scheduler sharing the single outbound frame-assembly path between
// eight TX packet streams. The winner is captured in a one-entry registered
// output stage together with its channel number.
//
// Ports:
//   CLK_IN    sole clock
//   RESET_IN  asynchronous, active-low reset
//   bus       spio_hss_multiplexer_tx_scheduler_if.slave (packet inputs,
//             output stage, flow control and counter read port)
//
// Optional feature: define SPIO_HSS_MULTIPLEXER_TX_SCHED_COUNTERS_EN to add
// eight per-channel grant counters plus a back-pressure cycle counter, read
// through REG_ADDR_IN / REG_DATA_OUT. Without it REG_DATA_OUT is tied to 0.
// -----------------------------------------------------------------------------
module spio_hss_multiplexer_tx_scheduler #(
    parameter int PKT_BITS = 72
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    spio_hss_multiplexer_tx_scheduler_if.slave bus
);
    localparam int NUM_CHANS = 8;

    logic [NUM_CHANS-1:0] eligible;
    logic                 stage_free;
    logic                 grant_found;
    logic                 grant_valid;
    logic [2:0]           grant_idx;
    logic [NUM_CHANS-1:0] grant_onehot;
    logic [2:0]           cand [NUM_CHANS];

    logic [2:0]           last_grant_q, last_grant_d;
    logic                 out_vld_q, out_vld_d;
    logic [PKT_BITS-1:0]  out_data_q, out_data_d;
    logic [2:0]           out_chan_q, out_chan_d;

    assign eligible   = bus.PKT_VLD_IN & ~bus.STOP_IN & {NUM_CHANS{bus.ENABLE_IN}};
    // The stage can take a new packet when empty or when it drains this cycle.
    assign stage_free = ~out_vld_q | bus.OUT_RDY_IN;

    // Search order: cand[0] is the channel after the last grant, wrapping mod 8.
    generate
        for (genvar gi = 0; gi < NUM_CHANS; gi++) begin : g_cand
            assign cand[gi] = last_grant_q + 3'(gi + 1);
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int k = 0; k < NUM_CHANS; k++) begin
            if (!grant_found && eligible[cand[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[k];
            end
        end
    end

    // RESET_IN gates ready so it is held low throughout reset.
    assign grant_valid = stage_free & grant_found & RESET_IN;

    generate
        for (genvar gi = 0; gi < NUM_CHANS; gi++) begin : g_rdy
            assign grant_onehot[gi] = grant_valid && (grant_idx == 3'(gi));
        end
    endgenerate

    assign bus.PKT_RDY_OUT = grant_onehot;

    always_comb begin
        last_grant_d = last_grant_q;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        if (stage_free) begin
            // Either load the winner or go empty; last_grant only moves on a grant.
            out_vld_d = grant_found;
            if (grant_found) begin
                out_data_d   = bus.PKT_DATA_IN[grant_idx*PKT_BITS +: PKT_BITS];
                out_chan_d   = grant_idx;
                last_grant_d = grant_idx;
            end
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            last_grant_q <= 3'd7;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
        end
    end

    assign bus.OUT_VLD_OUT  = out_vld_q;
    assign bus.OUT_DATA_OUT = out_data_q;
    assign bus.OUT_CHAN_OUT = out_chan_q;

`ifdef SPIO_HSS_MULTIPLEXER_TX_SCHED_COUNTERS_EN
    // Entries 0..7 count grants per channel, entry 8 counts stalled cycles.
    logic [31:0] cnt_q [NUM_CHANS+1];
    logic [31:0] reg_data;

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            for (int k = 0; k <= NUM_CHANS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CHANS; k++) begin
                if (grant_onehot[k]) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
            if (out_vld_q && !bus.OUT_RDY_IN) begin
                cnt_q[NUM_CHANS] <= cnt_q[NUM_CHANS] + 32'd1;
            end
        end
    end

    always_comb begin
        reg_data = '0;
        for (int k = 0; k <= NUM_CHANS; k++) begin
            if (bus.REG_ADDR_IN == 4'(k)) begin
                reg_data = cnt_q[k];
            end
        end
    end

    assign bus.REG_DATA_OUT = reg_data;
`else
    logic unused_reg_addr;
    assign unused_reg_addr  = ^bus.REG_ADDR_IN;
    assign bus.REG_DATA_OUT = '0;
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_tx_scheduler.sv
module tb_spio_hss_multiplexer_tx_scheduler;
    localparam int PB = 72;
`ifdef SPIO_HSS_MULTIPLEXER_TX_SCHED_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spio_hss_multiplexer_tx_scheduler_if #(.PKT_BITS(PB)) bus ();

    spio_hss_multiplexer_tx_scheduler #(.PKT_BITS(PB)) dut (
        .CLK_IN   (clk),
        .RESET_IN (rst_n),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // Held packet, last winner and counters, updated from the stated rules.
    logic          m_vld;
    logic [PB-1:0] m_data;
    int            m_chan;
    int            m_last;
    logic [31:0]   m_cnt [9];

    function automatic logic [PB-1:0] pkt_of(input int c);
        return bus.PKT_DATA_IN[c*PB +: PB];
    endfunction

    // Channel the rules grant this cycle, or -1.
    function automatic int model_pick();
        if (m_vld && !bus.OUT_RDY_IN) return -1;
        if (!bus.ENABLE_IN) return -1;
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (m_last + k) % 8;
            if (bus.PKT_VLD_IN[c] && !bus.STOP_IN[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_chan <= 0;
            m_last <= 7;
            for (int k = 0; k < 9; k++) m_cnt[k] <= '0;
        end else begin
            int g;
            g = model_pick();
            if (m_vld && !bus.OUT_RDY_IN) m_cnt[8] <= m_cnt[8] + 1;
            if (!m_vld || bus.OUT_RDY_IN) begin
                if (g >= 0) begin
                    m_vld    <= 1'b1;
                    m_data   <= pkt_of(g);
                    m_chan   <= g;
                    m_last   <= g;
                    m_cnt[g] <= m_cnt[g] + 1;
                end else begin
                    m_vld <= 1'b0;
                end
            end
        end
    end

    // Compare on every falling edge.
    always @(negedge clk) begin
        int g;
        logic [7:0]  exp_rdy;
        logic [31:0] exp_reg;
        g = model_pick();
        exp_rdy = (rst_n && g >= 0) ? (8'd1 << g) : 8'd0;
        exp_reg = 32'd0;
        if (CNT_EN && bus.REG_ADDR_IN <= 4'd8) exp_reg = m_cnt[bus.REG_ADDR_IN];
        chk("cyc_vld",  {127'd0, bus.OUT_VLD_OUT}, {127'd0, m_vld});
        chk("cyc_data", {56'd0, bus.OUT_DATA_OUT}, {56'd0, m_data});
        chk("cyc_chan", {125'd0, bus.OUT_CHAN_OUT}, 128'(m_chan));
        chk("cyc_rdy",  {120'd0, bus.PKT_RDY_OUT}, {120'd0, exp_rdy});
        chk("cyc_reg",  {96'd0, bus.REG_DATA_OUT}, {96'd0, exp_reg});
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    int fair_seq [16] = '{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7};
    int stop_seq [8]  = '{0,1,3,4,5,6,7,0};

    initial begin
        rst_n          = 1'b0;
        bus.ENABLE_IN  = 1'b1;
        bus.STOP_IN    = 8'h00;
        bus.PKT_VLD_IN = 8'h00;
        bus.OUT_RDY_IN = 1'b1;
        bus.REG_ADDR_IN = 4'd0;
        for (int i = 0; i < 8; i++) bus.PKT_DATA_IN[i*PB +: PB] = PB'(8'hA0 + i);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vld", {127'd0, bus.OUT_VLD_OUT}, 128'd0);
        chk("reset_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'd0);
        rst_n = 1'b1;

        // Fairness: all eligible, 1 packet per cycle in channel order.
        bus.PKT_VLD_IN = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("fair_chan", {125'd0, bus.OUT_CHAN_OUT}, 128'(fair_seq[i]));
            chk("fair_vld",  {127'd0, bus.OUT_VLD_OUT}, 128'd1);
        end
        @(posedge clk); #1 bus.PKT_VLD_IN = 8'h00;
        do_reset();

        // Stop mask on channel 2, then release it right after channel 1 wins.
        bus.STOP_IN = 8'h04; bus.PKT_VLD_IN = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stop_chan", {125'd0, bus.OUT_CHAN_OUT}, 128'(stop_seq[i]));
        end
        @(posedge clk); #1 bus.STOP_IN = 8'h00;
        @(negedge clk); chk("stop_rel1", {125'd0, bus.OUT_CHAN_OUT}, 128'd1);
        @(negedge clk); chk("stop_rel2", {125'd0, bus.OUT_CHAN_OUT}, 128'd2);
        @(posedge clk); #1 bus.PKT_VLD_IN = 8'h00;
        do_reset();

        // Back-pressure: channel 5 packet held for 4 stalled cycles.
        bus.PKT_VLD_IN = 8'h20;
        @(posedge clk); #1 bus.OUT_RDY_IN = 1'b0; bus.PKT_VLD_IN = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_data", {56'd0, bus.OUT_DATA_OUT}, 128'hA5);
            chk("bp_chan", {125'd0, bus.OUT_CHAN_OUT}, 128'd5);
            chk("bp_rdy",  {120'd0, bus.PKT_RDY_OUT}, 128'd0);
        end
        @(posedge clk); #1 bus.OUT_RDY_IN = 1'b1; bus.REG_ADDR_IN = 4'd8;
        #1;
        chk("bp_regrant", {120'd0, bus.PKT_RDY_OUT}, 128'h40);
        chk("bp_count", {96'd0, bus.REG_DATA_OUT}, CNT_EN ? 128'd4 : 128'd0);
        @(posedge clk); #1 bus.PKT_VLD_IN = 8'h00; bus.REG_ADDR_IN = 4'd0;
        do_reset();

        // Enable drop with a packet held.
        bus.PKT_VLD_IN = 8'h01; bus.OUT_RDY_IN = 1'b0;
        @(posedge clk); #1 bus.ENABLE_IN = 1'b0; bus.PKT_VLD_IN = 8'hFF;
        @(negedge clk);
        chk("en_hold_vld", {127'd0, bus.OUT_VLD_OUT}, 128'd1);
        chk("en_hold_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'd0);
        @(posedge clk); #1 bus.OUT_RDY_IN = 1'b1;
        @(negedge clk);
        chk("en_drain_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'd0);
        @(negedge clk);
        chk("en_idle_vld", {127'd0, bus.OUT_VLD_OUT}, 128'd0);
        @(posedge clk); #1 bus.ENABLE_IN = 1'b1;
        #1 chk("en_resume_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'h02);
        @(posedge clk); #1 bus.PKT_VLD_IN = 8'h00;
        do_reset();

        // Asynchronous reset between edges mid-transfer.
        bus.PKT_VLD_IN = 8'hFF;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("areset_vld", {127'd0, bus.OUT_VLD_OUT}, 128'd0);
        chk("areset_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'd0);
        @(posedge clk); #1 bus.PKT_VLD_IN = 8'h18; rst_n = 1'b1;
        #1 chk("areset_first_rdy", {120'd0, bus.PKT_RDY_OUT}, 128'h08);
        @(posedge clk); #1;
        chk("areset_first_chan", {125'd0, bus.OUT_CHAN_OUT}, 128'd3);
        bus.PKT_VLD_IN = 8'h00;
        do_reset();

        // Counters: 3 grants to channel 0, 2 to channel 7.
        bus.PKT_VLD_IN = 8'h01;
        repeat (3) @(posedge clk);
        #1 bus.PKT_VLD_IN = 8'h80;
        repeat (2) @(posedge clk);
        #1 bus.PKT_VLD_IN = 8'h00; bus.REG_ADDR_IN = 4'd0;
        #1 chk("cnt_ch0", {96'd0, bus.REG_DATA_OUT}, CNT_EN ? 128'd3 : 128'd0);
        bus.REG_ADDR_IN = 4'd7;
        #1 chk("cnt_ch7", {96'd0, bus.REG_DATA_OUT}, CNT_EN ? 128'd2 : 128'd0);
        bus.REG_ADDR_IN = 4'd12;
        #1 chk("cnt_addr12", {96'd0, bus.REG_DATA_OUT}, 128'd0);
        bus.REG_ADDR_IN = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
